// File: rtl/vx_perf_memsys_ctr_bank.sv
// vx_perf_memsys_ctr_bank
// Memory-system performance counter bank: NUM_CTRS event counters fed by
// multi-event-per-cycle increments, plus one latency accumulator (index
// NUM_CTRS) that integrates the outstanding-request count every enabled cycle.
// Live counters can be snapshotted atomically into a shadow bank, which is
// read back through a one-cycle indexed read port.
//
// Read handshake: rd_valid is a request strobe with no backpressure (a read
// may be issued every cycle); rd_rsp_valid pulses exactly one cycle later
// with the data/err for that request. rd_rsp_data holds between responses.
module vx_perf_memsys_ctr_bank #(
    parameter int NUM_CTRS  = 15,
    parameter int CTR_BITS  = 44,
    parameter int INC_BITS  = 4,
    parameter int PEND_BITS = 8,
    parameter int SATURATE  = 0,
    parameter int ADDR_BITS = $clog2(NUM_CTRS + 1)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic                              clear,
    input  logic [NUM_CTRS*INC_BITS-1:0]      evt_inc,
    input  logic                              lat_req_fire,
    input  logic                              lat_rsp_fire,
    input  logic                              snap_req,
    output logic                              snap_valid,
    input  logic                              rd_valid,
    input  logic [ADDR_BITS-1:0]              rd_addr,
    output logic                              rd_rsp_valid,
    output logic [CTR_BITS-1:0]               rd_rsp_data,
    output logic                              rd_rsp_err,
    output logic [(NUM_CTRS+1)*CTR_BITS-1:0]  ctr_live,
    output logic [NUM_CTRS:0]                 ovf,
    output logic [PEND_BITS-1:0]              pending,
    output logic                              pend_err
);

    localparam int NUM_ENT = NUM_CTRS + 1;

    logic [CTR_BITS-1:0]  ctr_q    [NUM_ENT];
    logic [CTR_BITS-1:0]  ctr_d    [NUM_ENT];
    logic [CTR_BITS-1:0]  shadow_q [NUM_ENT];
    logic [CTR_BITS-1:0]  shadow_d [NUM_ENT];
    logic [CTR_BITS-1:0]  inc_w    [NUM_ENT];
    logic [NUM_ENT-1:0]   ovf_q, ovf_d;
    logic [PEND_BITS-1:0] pend_q, pend_d;
    logic                 pend_err_q, pend_err_d;
    logic                 snap_valid_q, snap_valid_d;
    logic                 rd_rsp_valid_q, rd_rsp_valid_d;
    logic [CTR_BITS-1:0]  rd_rsp_data_q, rd_rsp_data_d;
    logic                 rd_rsp_err_q, rd_rsp_err_d;
    logic                 rd_addr_bad;

    // Per-entry increment: event slices, then the pre-update pending count
    // for the latency accumulator.
    for (genvar g = 0; g < NUM_CTRS; g++) begin : g_inc
        assign inc_w[g] = CTR_BITS'(evt_inc[g*INC_BITS +: INC_BITS]);
    end
    assign inc_w[NUM_CTRS] = CTR_BITS'(pend_q);

    // Flatten live counters for the readout side.
    for (genvar g = 0; g < NUM_ENT; g++) begin : g_live
        assign ctr_live[g*CTR_BITS +: CTR_BITS] = ctr_q[g];
    end

    // Counter next-state: add with carry detect, wrap or saturate, clear wins.
    always_comb begin
        logic [CTR_BITS:0] sum;
        ovf_d = ovf_q;
        sum   = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            ctr_d[i] = ctr_q[i];
            sum      = {1'b0, ctr_q[i]} + {1'b0, inc_w[i]};
            if (enable) begin
                if (sum[CTR_BITS]) begin
                    ovf_d[i] = 1'b1;
                    ctr_d[i] = (SATURATE != 0) ? {CTR_BITS{1'b1}} : sum[CTR_BITS-1:0];
                end else begin
                    ctr_d[i] = sum[CTR_BITS-1:0];
                end
            end
            if (clear) begin
                ctr_d[i] = '0;
            end
        end
        if (clear) begin
            ovf_d = '0;
        end
    end

    // Outstanding-request tracking; runs regardless of enable and clear.
    always_comb begin
        pend_d     = pend_q;
        pend_err_d = pend_err_q;
        if (lat_req_fire && !lat_rsp_fire) begin
            if (pend_q == {PEND_BITS{1'b1}}) begin
                pend_err_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_BITS'(1);
            end
        end else if (lat_rsp_fire && !lat_req_fire) begin
            if (pend_q == '0) begin
                pend_err_d = 1'b1;
            end else begin
                pend_d = pend_q - PEND_BITS'(1);
            end
        end
    end

    // Snapshot captures the live values as registered before this edge.
    always_comb begin
        snap_valid_d = snap_valid_q | snap_req;
        for (int i = 0; i < NUM_ENT; i++) begin
            shadow_d[i] = snap_req ? ctr_q[i] : shadow_q[i];
        end
    end

    // Read port reads the shadow as held before any same-cycle snapshot.
    assign rd_addr_bad = ({1'b0, rd_addr} >= (ADDR_BITS+1)'(NUM_ENT));

    // Read response next-state: strobe, data (held when idle), range error.
    always_comb begin
        rd_rsp_valid_d = rd_valid;
        rd_rsp_data_d  = rd_rsp_data_q;
        rd_rsp_err_d   = 1'b0;
        if (rd_valid) begin
            if (rd_addr_bad) begin
                rd_rsp_data_d = '0;
                rd_rsp_err_d  = 1'b1;
            end else begin
                rd_rsp_data_d = shadow_q[rd_addr];
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                ctr_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
            ovf_q          <= '0;
            pend_q         <= '0;
            pend_err_q     <= 1'b0;
            snap_valid_q   <= 1'b0;
            rd_rsp_valid_q <= 1'b0;
            rd_rsp_data_q  <= '0;
            rd_rsp_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENT; i++) begin
                ctr_q[i]    <= ctr_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            ovf_q          <= ovf_d;
            pend_q         <= pend_d;
            pend_err_q     <= pend_err_d;
            snap_valid_q   <= snap_valid_d;
            rd_rsp_valid_q <= rd_rsp_valid_d;
            rd_rsp_data_q  <= rd_rsp_data_d;
            rd_rsp_err_q   <= rd_rsp_err_d;
        end
    end

    assign ovf          = ovf_q;
    assign pending      = pend_q;
    assign pend_err     = pend_err_q;
    assign snap_valid   = snap_valid_q;
    assign rd_rsp_valid = rd_rsp_valid_q;
    assign rd_rsp_data  = rd_rsp_data_q;
    assign rd_rsp_err   = rd_rsp_err_q;

endmodule

// File: tb/tb_vx_perf_memsys_ctr_bank.sv
// Bench for vx_perf_memsys_ctr_bank: a wrap-mode and a saturate-mode instance
// share the same stimulus and are compared every cycle against an integer
// reference model of the counter bank.
module tb_vx_perf_memsys_ctr_bank;

    localparam int N  = 6;
    localparam int CB = 8;
    localparam int IB = 4;
    localparam int PB = 3;
    localparam int AB = 3;
    localparam int NE = N + 1;
    localparam int CMAX = 255;
    localparam int PMAX = 7;

    // clock / reset
    logic clk;
    logic reset_n;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic              enable, clear, lat_req_fire, lat_rsp_fire, snap_req, rd_valid;
    logic [N*IB-1:0]   evt_inc;
    logic [AB-1:0]     rd_addr;

    logic              snap_valid_w, rd_rsp_valid_w, rd_rsp_err_w, pend_err_w;
    logic [CB-1:0]     rd_rsp_data_w;
    logic [NE*CB-1:0]  ctr_live_w;
    logic [N:0]        ovf_w_o;
    logic [PB-1:0]     pending_w;

    logic              snap_valid_s, rd_rsp_valid_s, rd_rsp_err_s, pend_err_s;
    logic [CB-1:0]     rd_rsp_data_s;
    logic [NE*CB-1:0]  ctr_live_s;
    logic [N:0]        ovf_s_o;
    logic [PB-1:0]     pending_s;

    vx_perf_memsys_ctr_bank #(
        .NUM_CTRS(N), .CTR_BITS(CB), .INC_BITS(IB), .PEND_BITS(PB), .SATURATE(0), .ADDR_BITS(AB)
    ) dut_w (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .evt_inc(evt_inc),
        .lat_req_fire(lat_req_fire), .lat_rsp_fire(lat_rsp_fire), .snap_req(snap_req),
        .snap_valid(snap_valid_w), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_rsp_valid(rd_rsp_valid_w), .rd_rsp_data(rd_rsp_data_w), .rd_rsp_err(rd_rsp_err_w),
        .ctr_live(ctr_live_w), .ovf(ovf_w_o), .pending(pending_w), .pend_err(pend_err_w)
    );

    vx_perf_memsys_ctr_bank #(
        .NUM_CTRS(N), .CTR_BITS(CB), .INC_BITS(IB), .PEND_BITS(PB), .SATURATE(1), .ADDR_BITS(AB)
    ) dut_s (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .evt_inc(evt_inc),
        .lat_req_fire(lat_req_fire), .lat_rsp_fire(lat_rsp_fire), .snap_req(snap_req),
        .snap_valid(snap_valid_s), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_rsp_valid(rd_rsp_valid_s), .rd_rsp_data(rd_rsp_data_s), .rd_rsp_err(rd_rsp_err_s),
        .ctr_live(ctr_live_s), .ovf(ovf_s_o), .pending(pending_s), .pend_err(pend_err_s)
    );

    // reference model state
    int  m_live_w [NE];
    int  m_live_s [NE];
    int  m_sh_w   [NE];
    int  m_sh_s   [NE];
    bit  m_ovf_w  [NE];
    bit  m_ovf_s  [NE];
    int  m_pend;
    bit  m_perr;
    bit  m_snapv;
    bit  m_rv;
    bit  m_rerr;
    int  m_rdat_w;
    int  m_rdat_s;

    int  n_tests;
    int  n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_live_w[i] = 0; m_live_s[i] = 0; m_sh_w[i] = 0; m_sh_s[i] = 0;
            m_ovf_w[i] = 0;  m_ovf_s[i] = 0;
        end
        m_pend = 0; m_perr = 0; m_snapv = 0; m_rv = 0; m_rerr = 0;
        m_rdat_w = 0; m_rdat_s = 0;
    endtask

    // One clock edge worth of the counter bank's rules, using pre-edge values.
    task automatic model_edge();
        int inc;
        int s;
        m_rv = rd_valid;
        m_rerr = 0;
        if (rd_valid) begin
            if (int'(rd_addr) > N) begin
                m_rdat_w = 0; m_rdat_s = 0; m_rerr = 1;
            end else begin
                m_rdat_w = m_sh_w[rd_addr]; m_rdat_s = m_sh_s[rd_addr];
            end
        end
        if (snap_req) begin
            for (int i = 0; i < NE; i++) begin
                m_sh_w[i] = m_live_w[i]; m_sh_s[i] = m_live_s[i];
            end
            m_snapv = 1;
        end
        for (int i = 0; i < NE; i++) begin
            inc = (i < N) ? int'(evt_inc[i*IB +: IB]) : m_pend;
            if (enable) begin
                s = m_live_w[i] + inc;
                if (s > CMAX) begin m_ovf_w[i] = 1; s = s - (CMAX + 1); end
                m_live_w[i] = s;
                s = m_live_s[i] + inc;
                if (s > CMAX) begin m_ovf_s[i] = 1; s = CMAX; end
                m_live_s[i] = s;
            end
            if (clear) begin
                m_live_w[i] = 0; m_live_s[i] = 0; m_ovf_w[i] = 0; m_ovf_s[i] = 0;
            end
        end
        if (lat_req_fire && !lat_rsp_fire) begin
            if (m_pend == PMAX) m_perr = 1; else m_pend++;
        end else if (lat_rsp_fire && !lat_req_fire) begin
            if (m_pend == 0) m_perr = 1; else m_pend--;
        end
    endtask

    task automatic check_all(input string ph);
        logic [NE*CB-1:0] ew, es;
        logic [N:0]       ow, os;
        for (int i = 0; i < NE; i++) begin
            ew[i*CB +: CB] = CB'(m_live_w[i]);
            es[i*CB +: CB] = CB'(m_live_s[i]);
            ow[i] = m_ovf_w[i];
            os[i] = m_ovf_s[i];
        end
        chk({ph, " live_w"}, 64'(ctr_live_w), 64'(ew));
        chk({ph, " live_s"}, 64'(ctr_live_s), 64'(es));
        chk({ph, " ovf_w"}, 64'(ovf_w_o), 64'(ow));
        chk({ph, " ovf_s"}, 64'(ovf_s_o), 64'(os));
        chk({ph, " pending_w"}, 64'(pending_w), 64'(m_pend));
        chk({ph, " pending_s"}, 64'(pending_s), 64'(m_pend));
        chk({ph, " pend_err_w"}, 64'(pend_err_w), 64'(m_perr));
        chk({ph, " pend_err_s"}, 64'(pend_err_s), 64'(m_perr));
        chk({ph, " snap_valid_w"}, 64'(snap_valid_w), 64'(m_snapv));
        chk({ph, " snap_valid_s"}, 64'(snap_valid_s), 64'(m_snapv));
        chk({ph, " rd_rsp_valid_w"}, 64'(rd_rsp_valid_w), 64'(m_rv));
        chk({ph, " rd_rsp_valid_s"}, 64'(rd_rsp_valid_s), 64'(m_rv));
        chk({ph, " rd_rsp_data_w"}, 64'(rd_rsp_data_w), 64'(m_rdat_w));
        chk({ph, " rd_rsp_data_s"}, 64'(rd_rsp_data_s), 64'(m_rdat_s));
        if (m_rv) begin
            chk({ph, " rd_rsp_err_w"}, 64'(rd_rsp_err_w), 64'(m_rerr));
            chk({ph, " rd_rsp_err_s"}, 64'(rd_rsp_err_s), 64'(m_rerr));
        end
    endtask

    // driver: advance one clock, update model, sample #1 after the edge
    task automatic step(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic idle_inputs();
        clear = 0; snap_req = 0; rd_valid = 0; rd_addr = '0;
        lat_req_fire = 0; lat_rsp_fire = 0; evt_inc = '0;
    endtask

    task automatic set_evt(input int ch, input int v);
        evt_inc[ch*IB +: IB] = IB'(v);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        enable  = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // basic accumulation, snapshot and readback
        enable = 1;
        set_evt(0, 3);
        repeat (10) step("accum");
        chk("accum ctr0 is 30", 64'(ctr_live_w[7:0]), 64'd30);
        chk("accum no ovf", 64'(ovf_w_o), 64'd0);
        set_evt(0, 0);
        snap_req = 1;
        step("snap");
        snap_req = 0;
        rd_valid = 1; rd_addr = 3'd0;
        step("read0");
        rd_valid = 0;
        chk("read0 valid", 64'(rd_rsp_valid_w), 64'd1);
        chk("read0 data 30", 64'(rd_rsp_data_w), 64'd30);
        step("read0 idle");
        chk("read0 strobe drops", 64'(rd_rsp_valid_w), 64'd0);
        chk("read0 data held", 64'(rd_rsp_data_w), 64'd30);

        // wrap vs saturate on channel 2: 254 + 5
        clear = 1; step("clr"); clear = 0;
        set_evt(2, 15); repeat (16) step("fill");
        set_evt(2, 14); step("fill");
        chk("ctr2 at 254", 64'(ctr_live_w[2*CB +: CB]), 64'd254);
        set_evt(2, 5); step("ovf");
        set_evt(2, 0);
        chk("wrap ctr2 is 3", 64'(ctr_live_w[2*CB +: CB]), 64'd3);
        chk("sat ctr2 is 255", 64'(ctr_live_s[2*CB +: CB]), 64'd255);
        step("ovf sticky");
        chk("wrap ovf2 sticky", 64'(ovf_w_o[2]), 64'd1);
        chk("sat ovf2 sticky", 64'(ovf_s_o[2]), 64'd1);

        // latency accumulation: req at 0..2, rsp at 5..7
        clear = 1; step("clr"); clear = 0;
        for (int c = 0; c < 8; c++) begin
            lat_req_fire = (c < 3);
            lat_rsp_fire = (c >= 5);
            step("lat");
        end
        lat_req_fire = 0; lat_rsp_fire = 0;
        chk("latency sum 15", 64'(ctr_live_w[N*CB +: CB]), 64'd15);
        chk("latency pending 0", 64'(pending_w), 64'd0);
        chk("latency no pend_err", 64'(pend_err_w), 64'd0);

        // pending edge cases, with counting disabled
        enable = 0;
        lat_rsp_fire = 1; step("underflow"); lat_rsp_fire = 0;
        chk("underflow pending 0", 64'(pending_w), 64'd0);
        chk("underflow pend_err", 64'(pend_err_w), 64'd1);
        lat_req_fire = 1; repeat (2) step("req2");
        lat_rsp_fire = 1; step("req+rsp");
        chk("req+rsp pending 2", 64'(pending_w), 64'd2);
        lat_rsp_fire = 0; repeat (6) step("to max");
        chk("pending holds max", 64'(pending_w), 64'd7);
        lat_req_fire = 0; lat_rsp_fire = 1; repeat (7) step("drain");
        lat_rsp_fire = 0;
        chk("latency held while disabled", 64'(ctr_live_w[N*CB +: CB]), 64'd15);

        // clear + snapshot + read in one cycle
        enable = 1;
        clear = 1; step("clr"); clear = 0;
        set_evt(1, 5); step("c1=5");
        set_evt(1, 0); snap_req = 1; step("snap5"); snap_req = 0;
        set_evt(1, 2); step("c1=7");
        clear = 1; snap_req = 1; rd_valid = 1; rd_addr = 3'd1;
        step("clr+snap+rd");
        idle_inputs();
        chk("concurrent read old shadow", 64'(rd_rsp_data_w), 64'd5);
        chk("clear wins live1", 64'(ctr_live_w[CB +: CB]), 64'd0);
        rd_valid = 1; rd_addr = 3'd1; step("rd shadow1");
        chk("shadow1 pre-clear 7", 64'(rd_rsp_data_w), 64'd7);
        rd_addr = 3'd7; step("rd oob");
        chk("oob err", 64'(rd_rsp_err_w), 64'd1);
        chk("oob data 0", 64'(rd_rsp_data_w), 64'd0);
        rd_addr = 3'd6; step("rd lat entry");
        rd_valid = 0;

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            enable       = ($urandom_range(0, 9) < 8);
            clear        = ($urandom_range(0, 39) == 0);
            snap_req     = ($urandom_range(0, 9) == 0);
            rd_valid     = ($urandom_range(0, 1) == 1);
            rd_addr      = AB'($urandom_range(0, 7));
            lat_req_fire = ($urandom_range(0, 9) < 4);
            lat_rsp_fire = ($urandom_range(0, 9) < 4);
            for (int c = 0; c < N; c++) set_evt(c, $urandom_range(0, 15));
            step("rand");
        end

        // asynchronous reset mid-count, with a read in flight
        rd_valid = 1; rd_addr = 3'd0; enable = 1;
        step("pre-reset");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async reset");
        chk("async reset live", 64'(ctr_live_w), 64'd0);
        chk("async reset rsp dropped", 64'(rd_rsp_valid_w), 64'd0);
        idle_inputs();
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            enable       = 1;
            snap_req     = ($urandom_range(0, 7) == 0);
            rd_valid     = ($urandom_range(0, 1) == 1);
            rd_addr      = AB'($urandom_range(0, 7));
            lat_req_fire = ($urandom_range(0, 1) == 1);
            lat_rsp_fire = ($urandom_range(0, 1) == 1);
            for (int c = 0; c < N; c++) set_evt(c, $urandom_range(0, 15));
            step("post-reset");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
